voice_alloc: RTL and testbench
==============================

VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter NUM_VOICES, default `OSC_VOICES, number of oscillator voices managed; legal range 2..16.
REQ-002 Parameter NOTE_BITS, default `MIDI_PAYLOAD_BITS, width of a note number.
REQ-003 clk_i  input  1  system clock; the only clock, all logic on rising edge.
REQ-004 nrst_i  input  1  asynchronous active-low reset.
REQ-005 note_i  input  NOTE_BITS  note number from the MIDI decoder; valid only while a strobe is high.
REQ-006 noteOnStrb_i  input  1  one-cycle note-on pulse.
REQ-007 noteOffStrb_i  input  1  one-cycle note-off pulse.
REQ-008 voiceNote_o  output  NUM_VOICES*NOTE_BITS  per-voice note; voice v at bits [v*NOTE_BITS +: NOTE_BITS].
REQ-009 voiceGate_o  output  NUM_VOICES  per-voice gate; 1 = voice sounding.
REQ-010 voiceLoadStrb_o  output  NUM_VOICES  one-cycle pulse telling oscillator v to reload its phase increment from voiceNote_o.
REQ-011 activeCount_o  output  $clog2(NUM_VOICES+1)  number of gates currently set.
REQ-012 droppedStrb_o  output  1  one-cycle pulse when a note-on is discarded.

Function
REQ-013 All outputs are registered; each response appears exactly 1 cycle after the strobe cycle.
REQ-014 A strobe with note_i[NOTE_BITS-1] = 1 is ignored, with no output change and no droppedStrb_o pulse.
REQ-015 Note-on, note already gated in voice v: retrigger v by pulsing voiceLoadStrb_o[v] only; gate, note and allocation unchanged.
REQ-016 Note-on, note not gated and at least one free voice: allocate the lowest-index free voice v, set voiceNote_o[v] = note_i, set voiceGate_o[v] = 1 and pulse voiceLoadStrb_o[v].
REQ-017 Note-on, all voices gated: behaviour is set by REQ-026/REQ-027.
REQ-018 Note-off: clear voiceGate_o for every voice whose note equals note_i and whose gate is set; voiceNote_o is retained; no load strobe.
REQ-019 Note-off for a note not currently gated: no effect.
REQ-020 Note-on and note-off in the same cycle: note-off is processed and note-on is discarded without a droppedStrb_o pulse.
REQ-021 activeCount_o equals the popcount of voiceGate_o; it updates in the same cycle as the gates.
REQ-022 At most one voiceLoadStrb_o bit is high in any cycle, and only for one cycle.

Reset
REQ-023 While nrst_i = 0, all outputs are forced to 0 immediately: voiceNote_o, voiceGate_o, voiceLoadStrb_o, activeCount_o and droppedStrb_o.
REQ-024 When reset is deasserted, the age rank of voice v (see REQ-026) is v.
REQ-025 Reset asserted mid-operation discards any pending strobe; the first strobe after deassertion is handled normally.

Configuration
REQ-026 VOICE_STEAL_EN defined:
- Each voice holds an age rank 0..NUM_VOICES-1; rank 0 is newest.
- On every allocation or steal of voice v with old rank r, voices with rank < r increment and v becomes rank 0. A retrigger does not change ranks.
- Note-on with all voices gated steals the voice with rank NUM_VOICES-1: its note is replaced, its gate stays 1 and its load strobe pulses; droppedStrb_o stays 0.
REQ-027 VOICE_STEAL_EN undefined:
- No rank logic is synthesised.
- Note-on with all voices gated is discarded and droppedStrb_o pulses for 1 cycle.

Verification (NUM_VOICES = 4)
REQ-028 Note-on 60, 64, 67 in consecutive cycles -> voices 0/1/2 hold 60/64/67, gates 4'b0111, activeCount_o 3, load strobes on voices 0, 1, 2 in successive cycles.
REQ-029 Note-off 64, then note-on 72 -> voice 1 gate cleared, then voice 1 reallocated with 72; gates 4'b0111.
REQ-030 Five note-ons 60, 62, 64, 65, 67 -> with VOICE_STEAL_EN, voice 0 becomes 67 and droppedStrb_o stays 0; without it, the voices are unchanged and droppedStrb_o pulses once.
REQ-031 Note-on 60 twice -> the second produces only voiceLoadStrb_o[0]; activeCount_o stays 1.
REQ-032 Simultaneous note-on 62 and note-off 60 with 60 active -> gate 0 cleared, 62 not allocated, droppedStrb_o 0.
REQ-033 Reset asserted with 3 voices active -> all outputs 0 asynchronously; note-on 50 after release -> voice 0 = 50.

Source files
------------

// File: rtl/voice_alloc_if.sv
// ============================================================================
// Module   : voice_alloc_if
// Purpose  : Note/strobe bundle from the MIDI decoder into the voice allocator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

interface voice_alloc_if #(
    parameter int NOTE_BITS = `MIDI_PAYLOAD_BITS
);
    logic [NOTE_BITS-1:0] note_i;
    logic                 noteOnStrb_i;
    logic                 noteOffStrb_i;

    modport master (output note_i, output noteOnStrb_i, output noteOffStrb_i);
    modport slave  (input  note_i, input  noteOnStrb_i, input  noteOffStrb_i);
endinterface

`default_nettype wire

// File: rtl/voice_alloc.sv
// ============================================================================
// Module   : voice_alloc
// Purpose  : Polyphonic voice allocator; optional oldest-voice stealing
//            enabled by defining VOICE_STEAL_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef OSC_VOICES
`define OSC_VOICES 4
`endif
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

module voice_alloc #(
    parameter int NUM_VOICES = `OSC_VOICES,
    parameter int NOTE_BITS  = `MIDI_PAYLOAD_BITS
) (
    input  wire logic                                 clk_i,
    input  wire logic                                 nrst_i,
    voice_alloc_if.slave                              midi,
    output logic [NUM_VOICES*NOTE_BITS-1:0]           voiceNote_o,
    output logic [NUM_VOICES-1:0]                     voiceGate_o,
    output logic [NUM_VOICES-1:0]                     voiceLoadStrb_o,
    output logic [$clog2(NUM_VOICES+1)-1:0]           activeCount_o,
    output logic                                      droppedStrb_o
);

    localparam int c_cnt_w = $clog2(NUM_VOICES + 1);
    localparam int c_idx_w = $clog2(NUM_VOICES);

    logic [NOTE_BITS-1:0]  r_note [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate;
    logic [NUM_VOICES-1:0] r_load;
    logic                  r_dropped;
    logic [c_cnt_w-1:0]    r_count;

    logic                  w_valid;
    logic [NUM_VOICES-1:0] w_match;
    logic                  w_free_found;
    logic [c_idx_w-1:0]    w_free_idx;
    logic [c_idx_w-1:0]    w_match_idx;
    logic [NUM_VOICES-1:0] w_gate_nxt;
    logic [NUM_VOICES-1:0] w_load_nxt;
    logic                  w_dropped_nxt;
    logic                  w_write;
    logic [c_idx_w-1:0]    w_sel;
    logic [c_cnt_w-1:0]    w_count_nxt;

    // Notes with the top bit set are not MIDI payload and are ignored outright.
    assign w_valid = ~midi.note_i[NOTE_BITS-1];

    always_comb begin
        w_match      = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_match_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            w_match[v] = r_gate[v] && (r_note[v] == midi.note_i);
            if (!r_gate[v]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_idx_w'(v);
            end
            if (w_match[v]) begin
                w_match_idx = c_idx_w'(v);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [c_idx_w-1:0] r_rank [NUM_VOICES];
    logic [c_idx_w-1:0] w_victim_idx;

    always_comb begin
        w_victim_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_rank[v] == c_idx_w'(NUM_VOICES - 1)) begin
                w_victim_idx = c_idx_w'(v);
            end
        end
    end

    // Rank 0 is the newest voice; anything newer than the touched voice ages by one.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_rank[v] <= c_idx_w'(v);
            end
        end else if (w_write) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (c_idx_w'(v) == w_sel) begin
                    r_rank[v] <= '0;
                end else if (r_rank[v] < r_rank[w_sel]) begin
                    r_rank[v] <= r_rank[v] + 1'b1;
                end
            end
        end
    end
`endif

    // Note-off takes priority, so a coincident note-on is silently discarded.
    always_comb begin
        w_gate_nxt    = r_gate;
        w_load_nxt    = '0;
        w_dropped_nxt = 1'b0;
        w_write       = 1'b0;
        w_sel         = '0;
        if (w_valid && midi.noteOffStrb_i) begin
            w_gate_nxt = r_gate & ~w_match;
        end else if (w_valid && midi.noteOnStrb_i) begin
            if (|w_match) begin
                w_load_nxt[w_match_idx] = 1'b1;
            end else if (w_free_found) begin
                w_sel   = w_free_idx;
                w_write = 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
                w_sel   = w_victim_idx;
                w_write = 1'b1;
`else
                w_dropped_nxt = 1'b1;
`endif
            end
            if (w_write) begin
                w_gate_nxt[w_sel] = 1'b1;
                w_load_nxt[w_sel] = 1'b1;
            end
        end
    end

    always_comb begin
        w_count_nxt = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_count_nxt = w_count_nxt + c_cnt_w'(w_gate_nxt[v]);
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= '0;
            end
            r_gate    <= '0;
            r_load    <= '0;
            r_dropped <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_write) begin
                r_note[w_sel] <= midi.note_i;
            end
            r_gate    <= w_gate_nxt;
            r_load    <= w_load_nxt;
            r_dropped <= w_dropped_nxt;
            r_count   <= w_count_nxt;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_flat
        assign voiceNote_o[v*NOTE_BITS +: NOTE_BITS] = r_note[v];
    end

    assign voiceGate_o     = r_gate;
    assign voiceLoadStrb_o = r_load;
    assign activeCount_o   = r_count;
    assign droppedStrb_o   = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_voice_alloc.sv
// ============================================================================
// Module   : tb_voice_alloc
// Purpose  : Self-checking bench for voice_alloc (4 voices, 8-bit notes),
//            directed scenarios plus random traffic against a reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_voice_alloc;

    localparam int c_nv = 4;
    localparam int c_nb = 8;

    logic clk;
    logic nrst;

    logic [c_nv*c_nb-1:0] voice_note;
    logic [c_nv-1:0]      voice_gate;
    logic [c_nv-1:0]      voice_load;
    logic [2:0]           active_count;
    logic                 dropped;

    voice_alloc_if #(.NOTE_BITS(c_nb)) bus ();

    voice_alloc #(
        .NUM_VOICES (c_nv),
        .NOTE_BITS  (c_nb)
    ) dut (
        .clk_i           (clk),
        .nrst_i          (nrst),
        .midi            (bus),
        .voiceNote_o     (voice_note),
        .voiceGate_o     (voice_gate),
        .voiceLoadStrb_o (voice_load),
        .activeCount_o   (active_count),
        .droppedStrb_o   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: voice contents plus an age list, newest voice first.
    logic [7:0] m_note [c_nv];
    bit         m_gate [c_nv];
    int         age_q  [$];
    logic [3:0] exp_load;
    bit         exp_drop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < c_nv; v++) begin
            m_note[v] = '0;
            m_gate[v] = 1'b0;
        end
        age_q.delete();
        for (int v = 0; v < c_nv; v++) age_q.push_back(v);
        exp_load = '0;
        exp_drop = 1'b0;
    endfunction

    function automatic void touch(input int v);
        for (int i = 0; i < age_q.size(); i++) begin
            if (age_q[i] == v) begin
                age_q.delete(i);
                break;
            end
        end
        age_q.push_front(v);
    endfunction

    function automatic void model_step(input bit on, input bit off, input logic [7:0] n);
        int hit;
        int tgt;
        exp_load = '0;
        exp_drop = 1'b0;
        hit = -1;
        tgt = -1;
        if (n[7]) return;
        if (off) begin
            for (int v = 0; v < c_nv; v++)
                if (m_gate[v] && m_note[v] == n) m_gate[v] = 1'b0;
        end else if (on) begin
            for (int v = c_nv - 1; v >= 0; v--) begin
                if (m_gate[v] && m_note[v] == n) hit = v;
                if (!m_gate[v]) tgt = v;
            end
            if (hit >= 0) begin
                exp_load[hit] = 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
                if (tgt < 0) tgt = age_q[$];
`endif
                if (tgt < 0) begin
                    exp_drop = 1'b1;
                end else begin
                    m_note[tgt]   = n;
                    m_gate[tgt]   = 1'b1;
                    exp_load[tgt] = 1'b1;
                    touch(tgt);
                end
            end
        end
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] en;
        logic [3:0]  eg;
        for (int v = 0; v < c_nv; v++) begin
            en[v*8 +: 8] = m_note[v];
            eg[v]        = m_gate[v];
        end
        check({tag, ".note"},  64'(voice_note),   64'(en));
        check({tag, ".gate"},  64'(voice_gate),   64'(eg));
        check({tag, ".load"},  64'(voice_load),   64'(exp_load));
        check({tag, ".count"}, 64'(active_count), 64'($countones(eg)));
        check({tag, ".drop"},  64'(dropped),      64'(exp_drop));
    endtask

    task automatic drive(input string tag, input bit on, input bit off, input logic [7:0] n);
        @(negedge clk);
        bus.note_i        = n;
        bus.noteOnStrb_i  = on;
        bus.noteOffStrb_i = off;
        model_step(on, off, n);
        @(posedge clk);
        #1;
        bus.noteOnStrb_i  = 1'b0;
        bus.noteOffStrb_i = 1'b0;
        check_all(tag);
    endtask

    // Reset lands mid-cycle with a strobe pending; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        bus.note_i       = 8'd40;
        bus.noteOnStrb_i = 1'b1;
        nrst             = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(negedge clk);
        bus.noteOnStrb_i = 1'b0;
        nrst             = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, ".rel"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] n;
        int         r;
        nrst              = 1'b1;
        bus.note_i        = '0;
        bus.noteOnStrb_i  = 1'b0;
        bus.noteOffStrb_i = 1'b0;
        model_reset();

        do_reset("reset");

        drive("on60", 1, 0, 8'd60);
        drive("on64", 1, 0, 8'd64);
        drive("on67", 1, 0, 8'd67);
        check("req28.gate",  64'(voice_gate),   64'(4'b0111));
        check("req28.count", 64'(active_count), 64'd3);
        drive("off64", 0, 1, 8'd64);
        check("req29.gate1", 64'(voice_gate[1]), 64'd0);
        drive("on72", 1, 0, 8'd72);
        check("req29.note1", 64'(voice_note[15:8]), 64'd72);
        drive("idle", 0, 0, 8'd0);
        drive("inv_on",  1, 0, 8'd200);
        drive("inv_off", 0, 1, 8'd188);
        drive("off99", 0, 1, 8'd99);

        do_reset("rst3");
        for (int i = 0; i < 5; i++) begin
            n = (i == 0) ? 8'd60 : (i == 1) ? 8'd62 : (i == 2) ? 8'd64 : (i == 3) ? 8'd65 : 8'd67;
            drive("five", 1, 0, n);
        end
`ifdef VOICE_STEAL_EN
        check("req30.v0",   64'(voice_note[7:0]), 64'd67);
        check("req30.drop", 64'(dropped),         64'd0);
`else
        check("req30.v0",   64'(voice_note[7:0]), 64'd60);
        check("req30.drop", 64'(dropped),         64'd1);
`endif
        drive("idle", 0, 0, 8'd0);
        check("req30.drop_once", 64'(dropped), 64'd0);

        do_reset("rst_retrig");
        drive("on60a", 1, 0, 8'd60);
        drive("on60b", 1, 0, 8'd60);
        check("req31.load",  64'(voice_load),   64'(4'b0001));
        check("req31.count", 64'(active_count), 64'd1);
        drive("on_off", 1, 1, 8'd62);
        drive("on_off", 1, 1, 8'd60);
        check("req32.gate", 64'(voice_gate), 64'd0);
        check("req32.drop", 64'(dropped),    64'd0);

        drive("a", 1, 0, 8'd61);
        drive("b", 1, 0, 8'd63);
        drive("c", 1, 0, 8'd66);
        do_reset("req33");
        drive("on50", 1, 0, 8'd50);
        check("req33.v0", 64'(voice_note[7:0]), 64'd50);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 15) == 0) n = 8'h80 | 8'($urandom_range(0, 127));
            else                            n = 8'(60 + $urandom_range(0, 7));
            drive("rand", (r < 5) || (r == 8), (r >= 5 && r <= 8), n);
            if (i == 200) do_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
